// File: rtl/snn_core.sv
// snn_core: AXI4-Lite register file in front of a small fully connected
// integrate-and-fire network fed by rate-coded LFSR spike generators.
// Ports:
//   S_AXI_ACLK / S_AXI_ARESET   clock, synchronous active-high reset
//   S_AXI_AW*/W*/B*             write address, data and response channels
//   S_AXI_AR*/R*                read address and data channels
// Map: 0x0 CTRL {gen_en,run,clear}, 0x4 SEL {layer,neuron,mode},
//      0x8 OUT_SPIKES, 0xC SPIKE_COUNT, 0x100+k rate / weight window.
module snn_core #(
   parameter int        C_S_AXI_ACLK_FREQ_HZ = 100000000,
   parameter int        C_S_AXI_DATA_WIDTH   = 32,
   parameter int        C_S_AXI_ADDR_WIDTH   = 16,
   parameter int signed THRESH               = 4,
   parameter int signed RESET                = 0,
   parameter int        REFRAC               = 0,
   parameter int        WEIGHT_SIZE          = 9,
   parameter int        NUM_INPUTS           = 9,
   parameter int        NUM_LAYERS           = 2,
   parameter int        NUM_HIDDEN_LAYER_NEURONS [NUM_LAYERS] = '{3, 2}
) (
   input  logic                            S_AXI_ACLK,
   input  logic                            S_AXI_ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY
);

   function automatic int max_width();
      int m = NUM_INPUTS;
      for (int l = 0; l < NUM_LAYERS; l++)
         if (NUM_HIDDEN_LAYER_NEURONS[l] > m) m = NUM_HIDDEN_LAYER_NEURONS[l];
      return m;
   endfunction

   function automatic int fan_in(int l);
      if (l == 0) return NUM_INPUTS;
      return NUM_HIDDEN_LAYER_NEURONS[l-1];
   endfunction

   localparam int AW   = C_S_AXI_ADDR_WIDTH;
   localparam int DW   = C_S_AXI_DATA_WIDTH;
   localparam int WS   = WEIGHT_SIZE;
   localparam int SW   = WEIGHT_SIZE + 8;
   localparam int LAST = NUM_LAYERS - 1;
   localparam int NOUT = NUM_HIDDEN_LAYER_NEURONS[LAST];
   localparam int MAXW = max_width();
   localparam int SMAX = (1 << (SW - 1)) - 1;
   localparam int SMIN = -(1 << (SW - 1));
   localparam logic signed [SW-1:0] THR_S = SW'(THRESH);
   localparam logic signed [SW-1:0] RST_V = SW'(RESET);
   localparam logic [AW-1:0] ADDR_CTRL = AW'('h0);
   localparam logic [AW-1:0] ADDR_SEL  = AW'('h4);
   localparam logic [AW-1:0] ADDR_OUT  = AW'('h8);
   localparam logic [AW-1:0] ADDR_CNT  = AW'('hC);
   localparam int unused_freq = C_S_AXI_ACLK_FREQ_HZ;

   logic                    awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
   logic [DW-1:0]           rdata_q, rdata_d;
   logic [DW-1:0]           ctrl_q, sel_q;
   logic [31:0]             rate_q [NUM_INPUTS];
   logic [31:0]             lfsr_q [NUM_INPUTS];
   logic signed [WS-1:0]    w_q    [NUM_LAYERS][MAXW][MAXW];
   logic signed [SW-1:0]    v_q    [NUM_LAYERS][MAXW];
   logic [15:0]             ref_q  [NUM_LAYERS][MAXW];
   logic [MAXW-1:0]         spk_q  [NUM_LAYERS];
   logic [31:0]             cnt_q;
   logic [MAXW-1:0]         gen_spk;
   logic [MAXW-1:0]         lin    [NUM_LAYERS];
   logic signed [SW-1:0]    s_sat  [NUM_LAYERS][MAXW];
   logic [31:0]             pop;
   logic                    wr_fire, rd_fire, wr_win, rd_win;
   logic                    unused_bits;

   assign unused_bits = ^S_AXI_WSTRB;
   assign wr_fire = awready_q & S_AXI_AWVALID & wready_q & S_AXI_WVALID;
   assign rd_fire = arready_q & S_AXI_ARVALID;
   assign wr_win  = (S_AXI_AWADDR[AW-1:8] == (AW-8)'(1));
   assign rd_win  = (S_AXI_ARADDR[AW-1:8] == (AW-8)'(1));

   // ---------------- bus write side and configuration storage ----------------
   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         ctrl_q    <= '0;
         sel_q     <= '0;
         for (int k = 0; k < NUM_INPUTS; k++) rate_q[k] <= '0;
         for (int l = 0; l < NUM_LAYERS; l++)
            for (int n = 0; n < MAXW; n++)
               for (int f = 0; f < MAXW; f++) w_q[l][n][f] <= '0;
      end else begin
         awready_q <= !awready_q && S_AXI_AWVALID && S_AXI_WVALID;
         wready_q  <= !wready_q && S_AXI_AWVALID && S_AXI_WVALID;
         if (wr_fire)           bvalid_q <= 1'b1;
         else if (S_AXI_BREADY) bvalid_q <= 1'b0;
         if (wr_fire) begin
            if (S_AXI_AWADDR == ADDR_CTRL) ctrl_q <= S_AXI_WDATA;
            if (S_AXI_AWADDR == ADDR_SEL)  sel_q  <= S_AXI_WDATA;
            if (wr_win && sel_q[7:0] == 8'd0)
               for (int k = 0; k < NUM_INPUTS; k++)
                  if (S_AXI_AWADDR[7:0] == 8'(k)) rate_q[k] <= S_AXI_WDATA[31:0];
            if (wr_win && sel_q[7:0] == 8'd1)
               for (int l = 0; l < NUM_LAYERS; l++)
                  for (int n = 0; n < MAXW; n++)
                     for (int f = 0; f < MAXW; f++)
                        if (n < NUM_HIDDEN_LAYER_NEURONS[l] && f < fan_in(l) &&
                            sel_q[31:28] == 4'(l) && sel_q[27:8] == 20'(n) &&
                            S_AXI_AWADDR[7:0] == 8'(f))
                           w_q[l][n][f] <= S_AXI_WDATA[WS-1:0];
         end
      end
   end

   // ---------------- bus read side ----------------
   always_comb begin
      rdata_d = '0;
      case (S_AXI_ARADDR)
         ADDR_CTRL: rdata_d = ctrl_q;
         ADDR_SEL:  rdata_d = sel_q;
         ADDR_OUT:  for (int j = 0; j < NOUT; j++) rdata_d[j] = spk_q[LAST][j];
         ADDR_CNT:  rdata_d = DW'(cnt_q);
         default: begin
            if (rd_win && sel_q[7:0] == 8'd0)
               for (int k = 0; k < NUM_INPUTS; k++)
                  if (S_AXI_ARADDR[7:0] == 8'(k)) rdata_d = DW'(rate_q[k]);
            if (rd_win && sel_q[7:0] == 8'd1)
               for (int l = 0; l < NUM_LAYERS; l++)
                  for (int n = 0; n < MAXW; n++)
                     for (int f = 0; f < MAXW; f++)
                        if (n < NUM_HIDDEN_LAYER_NEURONS[l] && f < fan_in(l) &&
                            sel_q[31:28] == 4'(l) && sel_q[27:8] == 20'(n) &&
                            S_AXI_ARADDR[7:0] == 8'(f))
                           rdata_d = {{(DW-WS){w_q[l][n][f][WS-1]}}, w_q[l][n][f]};
         end
      endcase
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
      end else begin
         arready_q <= S_AXI_ARVALID && !arready_q && !rvalid_q;
         if (rd_fire) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rdata_d;
         end else if (S_AXI_RREADY) begin
            rvalid_q <= 1'b0;
         end
      end
   end

   // ---------------- spike generators ----------------
   // Fibonacci LFSR, polynomial x^32 + x^22 + x^2 + x + 1.
   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         for (int k = 0; k < NUM_INPUTS; k++) lfsr_q[k] <= 32'(k + 1);
      end else if (ctrl_q[2]) begin
         for (int k = 0; k < NUM_INPUTS; k++)
            lfsr_q[k] <= {lfsr_q[k][30:0],
                          lfsr_q[k][31] ^ lfsr_q[k][21] ^ lfsr_q[k][1] ^ lfsr_q[k][0]};
      end
   end

   always_comb begin
      gen_spk = '0;
      for (int k = 0; k < NUM_INPUTS; k++)
         gen_spk[k] = ctrl_q[2] && (lfsr_q[k] < rate_q[k]);
   end

   // ---------------- neuron layers ----------------
   always_comb begin
      for (int l = 0; l < NUM_LAYERS; l++) lin[l] = '0;
      lin[0] = gen_spk;
      for (int l = 1; l < NUM_LAYERS; l++) lin[l] = spk_q[l-1];
   end

   // Integrate in 32 bits (cannot overflow here), then clamp to SW bits.
   always_comb begin
      int acc;
      acc = 0;
      for (int l = 0; l < NUM_LAYERS; l++)
         for (int n = 0; n < MAXW; n++) begin
            acc = int'(v_q[l][n]);
            for (int f = 0; f < MAXW; f++)
               if (f < fan_in(l) && lin[l][f]) acc = acc + int'(w_q[l][n][f]);
            if (acc > SMAX)      s_sat[l][n] = SW'(SMAX);
            else if (acc < SMIN) s_sat[l][n] = SW'(SMIN);
            else                 s_sat[l][n] = SW'(acc);
         end
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET || ctrl_q[0]) begin
         for (int l = 0; l < NUM_LAYERS; l++) begin
            spk_q[l] <= '0;
            for (int n = 0; n < MAXW; n++) begin
               v_q[l][n]   <= RST_V;
               ref_q[l][n] <= '0;
            end
         end
      end else if (ctrl_q[1]) begin
         for (int l = 0; l < NUM_LAYERS; l++)
            for (int n = 0; n < MAXW; n++)
               if (n < NUM_HIDDEN_LAYER_NEURONS[l]) begin
                  if (ref_q[l][n] != '0) begin
                     ref_q[l][n]    <= ref_q[l][n] - 16'd1;
                     v_q[l][n]      <= RST_V;
                     spk_q[l][n]    <= 1'b0;
                  end else if (s_sat[l][n] >= THR_S) begin
                     spk_q[l][n]    <= 1'b1;
                     v_q[l][n]      <= RST_V;
                     ref_q[l][n]    <= 16'(REFRAC);
                  end else begin
                     spk_q[l][n]    <= 1'b0;
                     v_q[l][n]      <= s_sat[l][n];
                  end
               end
      end else begin
         for (int l = 0; l < NUM_LAYERS; l++) spk_q[l] <= '0;
      end
   end

   always_comb begin
      pop = '0;
      for (int j = 0; j < MAXW; j++) pop = pop + 32'(spk_q[LAST][j]);
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET || ctrl_q[0]) cnt_q <= '0;
      else                           cnt_q <= cnt_q + pop;
   end

   assign S_AXI_AWREADY = awready_q;
   assign S_AXI_WREADY  = wready_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = 2'b00;
   assign S_AXI_ARREADY = arready_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = 2'b00;

endmodule

// File: tb/tb_snn_core.sv
// Bench for snn_core: AXI master tasks, a cycle-level behavioural model of
// the register map and network, and randomized rate/weight stimulus.
module tb_snn_core;
   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] awaddr, araddr;
   logic        awvalid, wvalid, bready, arvalid, rready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        awready, wready, bvalid, arready, rvalid;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata;

   always #5 clk = ~clk;

   snn_core dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   localparam int NN [2] = '{3, 2};
   localparam int THR = 4;
   localparam int RSTV = 0;
   localparam int RFR = 0;

   int unsigned m_ctrl, m_sel, m_cnt;
   int unsigned m_rate [9];
   int unsigned m_lfsr [9];
   int          m_w    [2][3][9];
   int          m_v    [2][3];
   int          m_ref  [2][3];
   bit          m_spk  [2][3];
   int unsigned exp_rd;

   function automatic int fanin(int unsigned l);
      return (l == 0) ? 9 : NN[0];
   endfunction

   function automatic int unsigned lfsr_next(int unsigned x);
      bit fb;
      fb = x[31] ^ x[21] ^ x[1] ^ x[0];
      return {x[30:0], fb};
   endfunction

   task automatic m_reset();
      m_ctrl = 0; m_sel = 0; m_cnt = 0;
      for (int k = 0; k < 9; k++) begin m_rate[k] = 0; m_lfsr[k] = k + 1; end
      for (int l = 0; l < 2; l++)
         for (int n = 0; n < 3; n++) begin
            m_v[l][n] = RSTV; m_ref[l][n] = 0; m_spk[l][n] = 0;
            for (int f = 0; f < 9; f++) m_w[l][n][f] = 0;
         end
   endtask

   function automatic int unsigned m_read(int unsigned a);
      int unsigned k, mode, lay, neu, r;
      r = 0; k = a - 256; mode = m_sel & 255; lay = m_sel >> 28; neu = (m_sel >> 8) & 'hFFFFF;
      case (a)
         32'h0: r = m_ctrl;
         32'h4: r = m_sel;
         32'h8: r = {30'd0, m_spk[1][1], m_spk[1][0]};
         32'hC: r = m_cnt;
         default:
            if (a >= 256) begin
               if (mode == 0 && k < 9) r = m_rate[k];
               else if (mode == 1 && lay < 2)
                  if (neu < NN[lay] && k < fanin(lay)) r = m_w[lay][neu][k];
            end
      endcase
      return r;
   endfunction

   task automatic m_write(input int unsigned a, input int unsigned d);
      int unsigned k, mode, lay, neu;
      logic signed [8:0] ws;
      k = a - 256; mode = m_sel & 255; lay = m_sel >> 28; neu = (m_sel >> 8) & 'hFFFFF;
      ws = d[8:0];
      if (a == 0) m_ctrl = d;
      else if (a == 4) m_sel = d;
      else if (a >= 256) begin
         if (mode == 0 && k < 9) m_rate[k] = d;
         else if (mode == 1 && lay < 2)
            if (neu < NN[lay] && k < fanin(lay)) m_w[lay][neu][k] = ws;
      end
   endtask

   task automatic m_step();
      bit g [9];
      bit ns [2][3];
      bit x;
      int s;
      for (int k = 0; k < 9; k++) begin
         g[k] = m_ctrl[2] && (m_lfsr[k] < m_rate[k]);
         if (m_ctrl[2]) m_lfsr[k] = lfsr_next(m_lfsr[k]);
      end
      if (m_ctrl[0]) begin
         m_cnt = 0;
         for (int l = 0; l < 2; l++)
            for (int n = 0; n < 3; n++) begin m_v[l][n] = RSTV; m_ref[l][n] = 0; m_spk[l][n] = 0; end
      end else begin
         m_cnt = m_cnt + m_spk[1][0] + m_spk[1][1];
         for (int l = 0; l < 2; l++)
            for (int n = 0; n < 3; n++) ns[l][n] = 0;
         if (m_ctrl[1]) begin
            for (int l = 0; l < 2; l++)
               for (int n = 0; n < NN[l]; n++) begin
                  if (m_ref[l][n] > 0) begin
                     m_ref[l][n]--; m_v[l][n] = RSTV;
                  end else begin
                     s = m_v[l][n];
                     for (int f = 0; f < fanin(l); f++) begin
                        x = (l == 0) ? g[f] : m_spk[0][f];
                        if (x) s += m_w[l][n][f];
                     end
                     if (s > 65535) s = 65535;
                     if (s < -65536) s = -65536;
                     if (s >= THR) begin ns[l][n] = 1; m_v[l][n] = RSTV; m_ref[l][n] = RFR; end
                     else m_v[l][n] = s;
                  end
               end
         end
         m_spk = ns;
      end
   endtask

   // Model advances on every clock edge, tracking bus handshakes as a monitor.
   always @(posedge clk) begin
      bit wr;
      int unsigned wa, wd;
      if (rst) m_reset();
      else begin
         if (arvalid && arready) exp_rd = m_read(32'(araddr));
         wr = awvalid && awready && wvalid && wready;
         wa = 32'(awaddr); wd = wdata;
         m_step();
         if (wr) m_write(wa, wd);
      end
   end

   // ---------------- bus master tasks (called on negedge) ----------------
   task automatic axi_wr(input int unsigned a, input int unsigned d);
      bit got = 0;
      awaddr = a[15:0]; wdata = d; awvalid = 1; wvalid = 1;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (awready) got = 1;
      end
      if (!got) begin
         chk("aw_timeout", 0, 1);
         awvalid = 0; wvalid = 0;
         return;
      end
      @(negedge clk);
      awvalid = 0; wvalid = 0;
      chk("bvalid", 32'(bvalid), 1);
      chk("bresp", 32'(bresp), 0);
      bready = 1;
      @(negedge clk);
      bready = 0;
   endtask

   task automatic axi_rd(input int unsigned a, input string tag);
      bit got = 0;
      logic [31:0] first;
      araddr = a[15:0]; arvalid = 1;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (arready) got = 1;
      end
      if (!got) begin
         chk("ar_timeout", 0, 1);
         arvalid = 0;
         return;
      end
      @(negedge clk);
      first = rdata;
      chk(tag, rdata, exp_rd);
      chk("rresp", 32'(rresp), 0);
      // ARVALID stays up while RVALID is pending: no second read may start.
      @(negedge clk);
      chk("rvalid_hold", 32'(rvalid), 1);
      chk("arready_blocked", 32'(arready), 0);
      chk("rdata_hold", rdata, first);
      rready = 1; arvalid = 0;
      @(negedge clk);
      rready = 0;
      chk("rvalid_drop", 32'(rvalid), 0);
   endtask

   task automatic sel_w(input int l, input int n);
      axi_wr(4, (l << 28) | (n << 8) | 1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int v;
      rst = 1; awaddr = 0; araddr = 0; awvalid = 0; wvalid = 0; bready = 0;
      arvalid = 0; rready = 0; wdata = 0; wstrb = 4'hF;
      repeat (3) @(negedge clk);
      rst = 0;

      axi_rd(0, "rst_ctrl");
      chk("rst_ctrl_zero", exp_rd, 0);
      axi_rd(4, "rst_sel");
      axi_rd(8, "rst_out");
      axi_rd('hC, "rst_cnt");
      axi_rd('h100, "rst_rate0");

      axi_wr(0, 32'hDEADBEEF);
      axi_rd(0, "ctrl_deadbeef");
      chk("ctrl_deadbeef_const", rdata, 32'hDEADBEEF);
      axi_wr(0, 6);
      axi_rd(0, "ctrl6");
      axi_rd('h2000, "unmapped_rd");
      axi_wr('h2000, $urandom);
      axi_rd('h2000, "unmapped_wr");
      axi_rd(0, "ctrl_after_unmapped");

      axi_wr(4, 0);
      for (int i = 0; i < 9; i++) axi_wr('h100 + i, (32'hFFFFFFFF / 9) * i);
      for (int i = 0; i < 9; i++) axi_rd('h100 + i, "rate_rd");
      axi_wr('h109, $urandom);
      axi_rd('h109, "rate_oob");

      v = 1;
      for (int l = 0; l < 2; l++)
         for (int n = 0; n < NN[l]; n++) begin
            sel_w(l, n);
            for (int f = 0; f < fanin(l); f++) begin axi_wr('h100 + f, v); v++; end
         end
      for (int l = 0; l < 2; l++)
         for (int n = 0; n < NN[l]; n++) begin
            sel_w(l, n);
            for (int f = 0; f < fanin(l); f++) axi_rd('h100 + f, "w_rd");
         end
      sel_w(1, 1);
      axi_rd('h102, "w_last");
      chk("w_last_const", rdata, 33);
      sel_w(0, 0);
      axi_wr('h100, 'h1FF);
      axi_rd('h100, "w_neg1");
      axi_wr('h109, 7);  axi_rd('h109, "w_k_oob");
      sel_w(0, 3); axi_wr('h100, 7); axi_rd('h100, "w_neu_oob");
      sel_w(1, 0); axi_wr('h103, 7); axi_rd('h103, "w_fanin_oob");
      sel_w(2, 0); axi_wr('h100, 7); axi_rd('h100, "w_layer_oob");
      axi_wr(4, 2); axi_wr('h100, 7); axi_rd('h100, "mode_oob");

      // directed: only input 0 fires, all weights 4
      axi_wr(0, 1);
      axi_wr(4, 0);
      axi_wr('h100, 32'hFFFFFFFF);
      for (int i = 1; i < 9; i++) axi_wr('h100 + i, 0);
      for (int l = 0; l < 2; l++)
         for (int n = 0; n < NN[l]; n++) begin
            sel_w(l, n);
            for (int f = 0; f < fanin(l); f++) axi_wr('h100 + f, 4);
         end
      axi_wr(0, 6);
      axi_rd(8, "dir_out_early");
      repeat (3) @(negedge clk);
      axi_rd(8, "dir_out");
      chk("dir_out_const", rdata, 3);
      axi_rd('hC, "dir_cnt");
      axi_wr(0, 7);
      axi_rd(8, "clr_out");
      axi_rd('hC, "clr_cnt");
      chk("clr_cnt_const", rdata, 0);

      // randomized rates, weights and run lengths
      for (int it = 0; it < 5; it++) begin
         axi_wr(4, 0);
         for (int i = 0; i < 9; i++) axi_wr('h100 + i, $urandom);
         for (int l = 0; l < 2; l++)
            for (int n = 0; n < NN[l]; n++) begin
               sel_w(l, n);
               for (int f = 0; f < fanin(l); f++)
                  axi_wr('h100 + f, $urandom_range(0, 23) - 8);
            end
         axi_wr(0, (it == 3) ? 4 : 6);
         for (int r = 0; r < 4; r++) begin
            repeat ($urandom_range(3, 30)) @(negedge clk);
            axi_rd(8, "rnd_out");
            axi_rd('hC, "rnd_cnt");
         end
      end

      // saturation: drive layer-0 potentials far negative, then climb back
      axi_wr(0, 1);
      axi_wr(4, 0);
      for (int i = 0; i < 9; i++) axi_wr('h100 + i, 32'hFFFFFFFF);
      for (int n = 0; n < 3; n++) begin
         sel_w(0, n);
         for (int f = 0; f < 8; f++) axi_wr('h100 + f, 32'hFFFFFF00);
         axi_wr('h108, 255);
      end
      for (int n = 0; n < 2; n++) begin
         sel_w(1, n);
         for (int f = 0; f < 3; f++) axi_wr('h100 + f, 10);
      end
      axi_wr(4, 0);
      axi_wr(0, 6);
      repeat (100) @(negedge clk);
      axi_rd('hC, "sat_cnt_low");
      for (int i = 0; i < 8; i++) axi_wr('h100 + i, 0);
      for (int r = 0; r < 12; r++) begin
         repeat (25) @(negedge clk);
         axi_rd(8, "sat_out");
         axi_rd('hC, "sat_cnt");
      end

      // reset during a write: no update, no response, everything cleared
      awaddr = 4; wdata = 32'h12345678; awvalid = 1; wvalid = 1;
      begin
         bit got = 0;
         for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (awready) got = 1;
         end
         if (!got) chk("rst_aw_timeout", 0, 1);
      end
      rst = 1;
      @(negedge clk);
      awvalid = 0; wvalid = 0;
      chk("rst_no_bvalid", 32'(bvalid), 0);
      @(negedge clk);
      rst = 0;
      axi_rd(4, "rst2_sel");
      chk("rst2_sel_const", rdata, 0);
      axi_rd(0, "rst2_ctrl");
      axi_rd('hC, "rst2_cnt");
      axi_rd(8, "rst2_out");
      axi_rd('h100, "rst2_rate0");

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

   initial begin
      #500000;
      n_err++;
      $display("FAIL watchdog observed=timeout expected=finish");
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/snn_core.md
# snn_core

Memory-mapped spiking-neural-network core: an AXI4-Lite slave register file in front of a small fully-connected, multi-layer integrate-and-fire network driven by rate-coded random spike generators. Host software writes input spike rates and synapse weights through the bus, enables the network, and reads back output-layer spike activity. It is the top of the SNN accelerator and attaches directly to the processor's AXI4-Lite interconnect.

## Interface
- C_S_AXI_ACLK_FREQ_HZ, 100000000, clock frequency (informational only).
- C_S_AXI_DATA_WIDTH, 32, bus data width.
- C_S_AXI_ADDR_WIDTH, 16, bus address width.
- THRESH, 4, firing threshold, signed.
- RESET, 0, post-spike membrane value, signed.
- REFRAC, 0, refractory cycles after a spike.
- WEIGHT_SIZE, 9, synapse weight width, signed two's complement.
- NUM_INPUTS, 9, number of spike generators.
- NUM_LAYERS, 2, number of neuron layers.
- NUM_HIDDEN_LAYER_NEURONS, {3,2}, unpacked 32-bit array giving the neuron count per layer.

Ports. Clock and reset come first.
- S_AXI_ACLK  in  1  sole clock. All logic acts on its rising edge.
- S_AXI_ARESET  in  1  synchronous, active-high reset.
- S_AXI_AWADDR  in  16; S_AXI_AWVALID  in  1; S_AXI_AWREADY  out  1.
- S_AXI_WDATA  in  32; S_AXI_WSTRB  in  4 (ignored; full-word writes only); S_AXI_WVALID  in  1; S_AXI_WREADY  out  1.
- S_AXI_BRESP  out  2; S_AXI_BVALID  out  1; S_AXI_BREADY  in  1.
- S_AXI_ARADDR  in  16; S_AXI_ARVALID  in  1; S_AXI_ARREADY  out  1.
- S_AXI_RDATA  out  32; S_AXI_RRESP  out  2; S_AXI_RVALID  out  1; S_AXI_RREADY  in  1.

## Operation
Register map. Addresses are byte addresses and are decoded exactly; there is no word alignment or shifting.
- 0x0000 CTRL, RW, 32 bits, full readback.
  - bit0: clear. While 1, all potentials are held at RESET, refractory counters at 0, spikes at 0 and the spike counter at 0.
  - bit1: network run.
  - bit2: spike-generator enable.
- 0x0004 SEL, RW, 32 bits.
  - [7:0] mode: 0 = input-rate window, 1 = synapse-weight window.
  - [27:8] neuron index.
  - [31:28] layer index.
- 0x0008 OUT_SPIKES, RO: bit j = current spike of output-layer neuron j.
- 0x000C SPIKE_COUNT, RO: 32-bit count of output-layer spikes, wrapping.
- 0x0100+k window.
  - Mode 0: k < NUM_INPUTS addresses the 32-bit RATE[k].
  - Mode 1: k < fan-in addresses weight k of the selected neuron. Fan-in is NUM_INPUTS for layer 0, otherwise the neuron count of the previous layer.
  - Weight writes store WDATA[WEIGHT_SIZE-1:0]. Weight reads return the value sign-extended to 32 bits.
- Out-of-range k, layer, neuron or mode, and unmapped addresses: writes are ignored and reads return 0. BRESP and RRESP are always 0 (OKAY).

Spike generators (each cycle when CTRL[2]=1):
- Each input has a 32-bit maximal-length LFSR with a distinct nonzero seed (seed = input index + 1) that advances one step per cycle.
- spike_in[k] = (lfsr[k] < RATE[k]). A rate of 0 never spikes.
- When CTRL[2]=0, generators output 0 and LFSRs hold.

Neurons (each cycle when CTRL[1]=1 and CTRL[0]=0):
- Layer L takes as inputs the registered spikes of layer L-1; layer 0 takes the generator outputs.
- If refrac_cnt > 0, the counter decrements, v stays at RESET and spike = 0.
- Otherwise: s = v + sum of weights of spiking inputs, computed at WEIGHT_SIZE+8-bit signed width and saturating.
- If s >= THRESH: spike = 1, v = RESET, refrac_cnt = REFRAC. Else spike = 0, v = s. There is no leak.
- When CTRL[1]=0, all state holds and spikes are 0.
- SPIKE_COUNT adds the popcount of output-layer spikes every cycle.

## Timing
- Reset values: all registers, RATE, weights, spikes and counters are 0; v = RESET; all AXI outputs are 0.
- Write handshake:
  - AWREADY and WREADY rise together for one cycle, the cycle after AWVALID & WVALID are both seen while AWREADY=0.
  - The register update and BVALID=1 occur on the edge where valid & ready are both sampled high.
  - BVALID holds until BREADY is sampled high.
  - A new write is accepted even while BVALID is pending; responses merge.
- Read handshake:
  - ARREADY pulses for one cycle after ARVALID is seen with ARREADY=0 and RVALID=0.
  - On the handshake edge, RDATA is latched and RVALID=1.
  - RDATA and RVALID hold until RREADY is sampled high.
  - No new read is accepted while RVALID=1.
- Latency:
  - A weight or rate write affects the network from the next cycle.
  - A generator spike reaches a layer-(N-1) spike output N cycles later.
  - OUT_SPIKES reads the value registered at the AR handshake edge.
- Reset asserted mid-transaction aborts it: no register update and no response.

## Test plan
- Write 0x0=0xDEADBEEF, then read 0x0 → 0xDEADBEEF, BRESP=RRESP=0, one ARREADY pulse, RVALID held until RREADY.
- Write CTRL=0x6 and read it back → 0x00000006. Read 0x2000 → 0; a write there changes nothing.
- With SEL=0, write RATE[i]=(0xFFFFFFFF/9)*i for i=0..8 and read back each → exact values. Write 0x0109 → ignored, reads 0.
- Set SEL=1 and for each layer/neuron write SEL={layer,neuron,8'h1}. Write weights 1..33 sequentially (27 for layer 0, then 6 for layer 1). Read back → 1..33. A weight write of 0x1FF reads back as 0xFFFFFFFF.
- RATE[0]=0xFFFFFFFF, others 0, all weights 4, THRESH=4, CTRL=0x6 → layer-0 neurons spike from cycle 2, output neurons spike from cycle 3, SPIKE_COUNT increases.
- Set CTRL bit0=1 mid-run → OUT_SPIKES=0 and SPIKE_COUNT=0 next cycle. Asserting reset clears all registers to 0.
